// File: rtl/core_run_ctrl.sv
// Run controller: programmable core-clock divider, core launch,
// busy/done/timeout aggregation and run-length measurement.
module core_run_ctrl #(
    parameter int NUM_CORES   = 2,
    parameter int DIV_WIDTH   = 4,
    parameter int DEFAULT_DIV = 4,
    parameter int CYC_WIDTH   = 32,
    parameter int TIMEOUT     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [DIV_WIDTH-1:0] i_div_sel,
    input  logic [NUM_CORES-1:0] i_core_busy,
    output logic                 o_core_clk,
    output logic                 o_core_ce,
    output logic [NUM_CORES-1:0] o_core_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic [CYC_WIDTH-1:0] o_cycles
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RUN,
        S_DONE,
        S_FAULT
    } state_e;

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] n_minus1;
    logic                 half_end;
    logic                 clk_q, clk_d;
    logic                 ce_q, ce_d;
    logic                 start_q, start_d;
    logic                 start_edge;

    state_e               state_q, state_d;
    logic                 launch_q, launch_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [NUM_CORES-1:0] core_start_q, core_start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic [CYC_WIDTH-1:0] cycles_q, cycles_d;
    logic [CYC_WIDTH-1:0] cycles_inc;

    // Divider: toggle at the end of each half-period, reload ratio there
    always_comb begin
        n_minus1 = (div_q == '0) ? '0 : div_q - DIV_WIDTH'(1);
        half_end = (cnt_q == n_minus1);
        cnt_d    = half_end ? '0 : cnt_q + DIV_WIDTH'(1);
        clk_d    = half_end ? ~clk_q : clk_q;
        div_d    = half_end ? i_div_sel : div_q;
        ce_d     = half_end & ~clk_q;
        start_d  = i_start;
    end

    assign start_edge = i_start & ~start_q;
    assign cycles_inc = (cycles_q == '1) ? cycles_q
                                         : cycles_q + CYC_WIDTH'(1);

    // Run FSM next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        launch_d     = launch_q;
        tcnt_d       = tcnt_q;
        core_start_d = core_start_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        cycles_d     = cycles_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d      = S_LAUNCH;
                    cycles_d     = '0;
                    core_start_d = '1;
                    busy_d       = 1'b1;
                    launch_d     = 1'b0;
                end
            end
            S_LAUNCH: begin
                if (ce_q) begin
                    cycles_d = cycles_inc;
                    if (launch_q) begin
                        state_d      = S_WAIT;
                        core_start_d = '0;
                        tcnt_d       = '0;
                    end else begin
                        launch_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (ce_q) begin
                    cycles_d = cycles_inc;
                    if (|i_core_busy) begin
                        state_d = S_RUN;
                    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        state_d   = S_FAULT;
                        timeout_d = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            S_RUN: begin
                if (ce_q) begin
                    cycles_d = cycles_inc;
                    if (i_core_busy == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE, S_FAULT: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d      = S_IDLE;
                busy_d       = 1'b0;
                core_start_d = '0;
            end
        endcase
    end

    // Divider and start-edge registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            div_q   <= DIV_WIDTH'(DEFAULT_DIV);
            clk_q   <= 1'b0;
            ce_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            clk_q   <= clk_d;
            ce_q    <= ce_d;
            start_q <= start_d;
        end
    end

    // Run FSM state and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            launch_q     <= 1'b0;
            tcnt_q       <= '0;
            core_start_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            cycles_q     <= '0;
        end else begin
            state_q      <= state_d;
            launch_q     <= launch_d;
            tcnt_q       <= tcnt_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            cycles_q     <= cycles_d;
        end
    end

    assign o_core_clk   = clk_q;
    assign o_core_ce    = ce_q;
    assign o_core_start = core_start_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_timeout    = timeout_q;
    assign o_cycles     = cycles_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: divider vectors, random divider model,
// run-scenario table, random runs, reset mid-run.
module tb_core_run_ctrl;

    localparam int NC  = 2;
    localparam int DW  = 4;
    localparam int DEF = 4;
    localparam int CW  = 32;
    localparam int TO  = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [DW-1:0] i_div_sel = 4'd4;
    logic [NC-1:0] i_core_busy = '0;
    logic          o_core_clk;
    logic          o_core_ce;
    logic [NC-1:0] o_core_start;
    logic          o_busy;
    logic          o_done;
    logic          o_timeout;
    logic [CW-1:0] o_cycles;

    core_run_ctrl #(
        .NUM_CORES  (NC),
        .DIV_WIDTH  (DW),
        .DEFAULT_DIV(DEF),
        .CYC_WIDTH  (CW),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_div_sel   (i_div_sel),
        .i_core_busy (i_core_busy),
        .o_core_clk  (o_core_clk),
        .o_core_ce   (o_core_ce),
        .o_core_start(o_core_start),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_timeout   (o_timeout),
        .o_cycles    (o_cycles)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Clock reference: countdown of i_clk cycles left in the current half
    int   m_left;
    logic m_clk;
    logic m_ce;
    bit   chk_clk = 1'b0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_left = DEF;
            m_clk  = 1'b0;
            m_ce   = 1'b0;
        end else begin
            m_left = m_left - 1;
            m_ce   = 1'b0;
            if (m_left == 0) begin
                m_clk  = ~m_clk;
                m_ce   = m_clk;
                m_left = (i_div_sel == 0) ? 1 : int'(i_div_sel);
            end
        end
    end

    always @(negedge i_clk) begin
        if (chk_clk) begin
            check("core_clk", o_core_clk, m_clk);
            check("core_ce", o_core_ce, m_ce);
        end
    end

    typedef struct {
        logic [DW-1:0] sel;
        int            period;
        int            high;
    } div_vec_t;

    typedef struct {
        int f0;
        int t0;
        int f1;
        int t1;
        int glitch;
        bit exp_done;
        int exp_cyc;
    } run_vec_t;

    div_vec_t dv[6];
    run_vec_t rv[8];

    task automatic wait_ce();
        int c;
        c = 0;
        do begin
            @(negedge i_clk);
            c++;
        end while (!o_core_ce && c < 200);
        if (!o_core_ce) check("ce_wait_bound", 0, 1);
    endtask

    task automatic measure(output int p, output int hi, output bit coinc);
        logic cur;
        logic last;
        p   = 0;
        hi  = 0;
        cur = o_core_clk;
        do begin
            last = cur;
            @(negedge i_clk);
            cur = o_core_clk;
            p++;
            if (cur) hi++;
        end while (!o_core_ce && p < 100);
        coinc = o_core_ce && cur && !last;
    endtask

    // Spec-level outcome of a run, indexed by ce pulse number
    function automatic void model_run(input run_vec_t v, output bit done,
                                      output int cyc);
        bit running;
        bit b;
        running = 1'b0;
        done    = 1'b0;
        cyc     = 0;
        for (int k = 3; k < 1000; k++) begin
            b = (k >= v.f0 && k < v.t0) || (k >= v.f1 && k < v.t1);
            if (!running) begin
                if (b) begin
                    running = 1'b1;
                end else if (k - 2 == TO) begin
                    cyc = k;
                    return;
                end
            end else if (!b) begin
                done = 1'b1;
                cyc  = k;
                return;
            end
        end
    endfunction

    task automatic do_run(input run_vec_t v, input string tag);
        logic [NC-1:0] ones;
        int  k;
        int  st_ce;
        int  n_done;
        int  n_to;
        int  end_k;
        int  end_cyc;
        int  c;
        int  bad;
        bit  glitch_low;
        ones       = '1;
        k          = 0;
        st_ce      = 0;
        n_done     = 0;
        n_to       = 0;
        end_k      = -1;
        end_cyc    = 0;
        glitch_low = 1'b0;
        i_start     = 1'b0;
        i_core_busy = '0;
        repeat (3) @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        check({tag, "_cyc_clear"}, o_cycles, 0);
        check({tag, "_busy_up"}, o_busy, 1);
        check({tag, "_start_on"}, o_core_start, ones);
        c = 0;
        while (end_k < 0 && c < 4000) begin
            if (glitch_low) begin
                i_start    = 1'b1;
                glitch_low = 1'b0;
            end
            if (o_done) n_done++;
            if (o_timeout) n_to++;
            if (o_done || o_timeout) begin
                end_k   = k;
                end_cyc = o_cycles;
            end
            if (o_core_ce && o_busy) begin
                k++;
                if (o_core_start == ones) st_ce++;
                i_core_busy[0] = (k >= v.f0 && k < v.t0);
                i_core_busy[1] = (k >= v.f1 && k < v.t1);
                if (k == v.glitch) begin
                    i_start    = 1'b0;
                    glitch_low = 1'b1;
                end
            end
            if (end_k < 0) @(negedge i_clk);
            c++;
        end
        i_core_busy = '0;
        if (end_k < 0) check({tag, "_end_bound"}, 0, 1);
        check({tag, "_done"}, n_done, v.exp_done ? 1 : 0);
        check({tag, "_timeout"}, n_to, v.exp_done ? 0 : 1);
        check({tag, "_cycles"}, end_cyc, v.exp_cyc);
        check({tag, "_start_ce"}, st_ce, 2);
        @(negedge i_clk);
        check({tag, "_busy_low"}, o_busy, 0);
        bad = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_busy || o_done || o_timeout || o_core_start != 0) bad++;
        end
        check({tag, "_no_relaunch"}, bad, 0);
        check({tag, "_cyc_held"}, o_cycles, v.exp_cyc);
        i_start = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       p;
        int       hi;
        bit       coinc;
        int       c;
        int       bad;
        run_vec_t r;

        dv[0] = '{4'd4, 8, 4};
        dv[1] = '{4'd0, 2, 1};
        dv[2] = '{4'd1, 2, 1};
        dv[3] = '{4'd7, 14, 7};
        dv[4] = '{4'd15, 30, 15};
        dv[5] = '{4'd2, 4, 2};

        rv[0] = '{3, 20, 3, 25, -1, 1'b1, 25};
        rv[1] = '{0, 0, 0, 0, -1, 1'b0, 18};
        rv[2] = '{18, 22, 0, 0, -1, 1'b1, 22};
        rv[3] = '{19, 25, 0, 0, -1, 1'b0, 18};
        rv[4] = '{3, 5, 4, 9, -1, 1'b1, 9};
        rv[5] = '{3, 5, 6, 9, -1, 1'b1, 5};
        rv[6] = '{1, 10, 0, 0, -1, 1'b1, 10};
        rv[7] = '{3, 30, 3, 30, 12, 1'b1, 30};

        repeat (3) @(negedge i_clk);
        check("rst_clk", o_core_clk, 0);
        check("rst_ce", o_core_ce, 0);
        check("rst_start", o_core_start, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_timeout", o_timeout, 0);
        check("rst_cycles", o_cycles, 0);
        #2 i_rst_n = 1'b1;
        c = 0;
        do begin
            @(negedge i_clk);
            c++;
        end while (!o_core_clk && c < 50);
        check("first_rise", c, DEF);
        chk_clk = 1'b1;

        foreach (dv[i]) begin
            i_div_sel = dv[i].sel;
            repeat (3) wait_ce();
            measure(p, hi, coinc);
            check($sformatf("period_sel%0d", dv[i].sel), p, dv[i].period);
            check($sformatf("high_sel%0d", dv[i].sel), hi, dv[i].high);
            check($sformatf("ce_rise_sel%0d", dv[i].sel), coinc, 1);
        end

        repeat (40) begin
            i_div_sel = DW'($urandom_range(0, 15));
            repeat ($urandom_range(1, 20)) @(negedge i_clk);
        end

        i_div_sel = 4'd2;
        foreach (rv[i]) do_run(rv[i], $sformatf("run%0d", i));

        for (int i = 0; i < 8; i++) begin
            r.f0     = $urandom_range(0, 22);
            r.t0     = r.f0 + $urandom_range(0, 15);
            r.f1     = $urandom_range(0, 22);
            r.t1     = r.f1 + $urandom_range(0, 15);
            r.glitch = $urandom_range(1, 30);
            model_run(r, r.exp_done, r.exp_cyc);
            i_div_sel = DW'($urandom_range(0, 5));
            do_run(r, $sformatf("rnd%0d", i));
        end

        i_div_sel   = 4'd2;
        i_core_busy = '1;
        i_start     = 1'b0;
        repeat (2) @(negedge i_clk);
        i_start = 1'b1;
        repeat (10) wait_ce();
        check("pre_rst_busy", o_busy, 1);
        i_start = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        check("mid_rst_clk", o_core_clk, 0);
        check("mid_rst_start", o_core_start, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_cycles", o_cycles, 0);
        check("mid_rst_pulse", o_done | o_timeout, 0);
        @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        i_core_busy = '0;
        c   = 0;
        bad = 0;
        do begin
            @(negedge i_clk);
            c++;
            if (o_done || o_timeout || o_busy) bad++;
        end while (!o_core_clk && c < 50);
        check("rst_first_half", c, DEF);
        measure(p, hi, coinc);
        check("rst_new_period", p, 4);
        check("rst_no_pulse", bad, 0);

        chk_clk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
